// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for the 16-bit pipeline: tracks in-flight register writes
// in a DEPTH-entry shift register and raises stall / forward selects at decode.
module hazard_scoreboard #(
  parameter int DEPTH    = 3,
  parameter int NREG     = 16,
  parameter int FWD_EN   = 0,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = 15,
  parameter int FW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [15:0]   id_instr,
  input  logic          flush,
  output logic          stall,
  output logic          hz_a,
  output logic          hz_b,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [15:0]   stall_cnt
);

  localparam int RW = $clog2(NREG);

  // Handshake: the ID instruction is accepted (and its write recorded) on a
  // rising edge where id_valid=1, stall=0 and flush=0; while stall=1 upstream
  // holds id_instr stable and a bubble enters the scoreboard instead.

  logic [3:0]    opcode;
  logic [RW-1:0] rd, rs, rt;
  logic [RW-1:0] a_reg, b_reg, wr_dst;
  logic          a_present, b_present, writes, is_load;

  assign opcode = id_instr[15:12];
  assign rd     = id_instr[8 +: RW];
  assign rs     = id_instr[4 +: RW];
  assign rt     = id_instr[0 +: RW];

  always_comb begin
    a_reg     = '0;
    b_reg     = '0;
    a_present = 1'b0;
    b_present = 1'b0;
    writes    = 1'b0;
    wr_dst    = rd;
    is_load   = 1'b0;
    case (opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        a_reg = rs; a_present = 1'b1;
        b_reg = rt; b_present = 1'b1;
        writes = 1'b1;
      end
      4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
        a_reg = rs; a_present = 1'b1;
        writes = 1'b1;
      end
      4'b1000: begin
        a_reg = rs; a_present = 1'b1;
        writes = 1'b1;
        is_load = 1'b1;
      end
      4'b1001: begin
        // Store: A carries the data register, B the address register.
        a_reg = rd; a_present = 1'b1;
        b_reg = rs; b_present = 1'b1;
      end
      4'b1010, 4'b1011: begin
        a_reg = rd; a_present = 1'b1;
        writes = 1'b1;
      end
      4'b1101: begin
        writes = 1'b1;
        wr_dst = RW'(LINK_REG);
      end
      4'b1110, 4'b1111: begin
        a_reg = rd; a_present = 1'b1;
      end
      default: begin
        a_present = 1'b0;
      end
    endcase
  end

  logic [DEPTH:1] sb_v;
  logic [DEPTH:1] sb_ld;
  logic [RW-1:0]  sb_dst [DEPTH:1];
  logic [DEPTH:1] match_a, match_b;
  logic           a_live, b_live, active;

  assign active = id_valid & ~flush;
  assign a_live = a_present & ~((ZERO_REG != 0) && (a_reg == '0));
  assign b_live = b_present & ~((ZERO_REG != 0) && (b_reg == '0));

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      match_a[k] = sb_v[k] & a_live & (sb_dst[k] == a_reg);
      match_b[k] = sb_v[k] & b_live & (sb_dst[k] == b_reg);
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites the result.
  logic [FW-1:0] near_a, near_b;

  always_comb begin
    near_a = '0;
    near_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (match_a[k]) near_a = FW'(k);
      if (match_b[k]) near_b = FW'(k);
    end
  end

  always_comb begin
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    fwd_a = '0;
    fwd_b = '0;
    if (active) begin
      if (FWD_EN != 0) begin
        fwd_a = near_a;
        fwd_b = near_b;
        hz_a  = (near_a == FW'(1)) & sb_ld[1];
        hz_b  = (near_b == FW'(1)) & sb_ld[1];
      end else begin
        hz_a = |match_a;
        hz_b = |match_b;
      end
    end
  end

  assign stall = active & (hz_a | hz_b);

  logic push;
  assign push = id_valid & ~stall & ~flush & writes &
                ~((ZERO_REG != 0) && (wr_dst == '0));

  // Entries shift every cycle, stalled or not, so a blocking producer always drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v  <= '0;
      sb_ld <= '0;
      for (int k = 1; k <= DEPTH; k++) sb_dst[k] <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_v[k]   <= sb_v[k-1];
        sb_ld[k]  <= sb_ld[k-1];
        sb_dst[k] <= sb_dst[k-1];
      end
      sb_v[1]   <= push;
      sb_ld[1]  <= push & is_load;
      sb_dst[1] <= wr_dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: table-driven vectors against stall/forward modes,
// hand-written reset-mid-stall sequence, and a long stall-counter saturation run.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst7_n;
  logic        v0, f0, v1, f1, v7, f7;
  logic [15:0] i0, i1, i7;
  logic        st0, ha0, hb0, st1, ha1, hb1, st7, ha7, hb7;
  logic [2:0]  fa0, fb0, fa1, fb1, fa7, fb7;
  logic [15:0] c0, c1, c7;

  hazard_scoreboard #(.DEPTH(3), .NREG(16), .FWD_EN(0), .ZERO_REG(1), .LINK_REG(15), .FW(3)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(v0), .id_instr(i0), .flush(f0),
    .stall(st0), .hz_a(ha0), .hz_b(hb0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(c0));

  hazard_scoreboard #(.DEPTH(3), .NREG(16), .FWD_EN(1), .ZERO_REG(1), .LINK_REG(15), .FW(3)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(v1), .id_instr(i1), .flush(f1),
    .stall(st1), .hz_a(ha1), .hz_b(hb1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(c1));

  hazard_scoreboard #(.DEPTH(7), .NREG(16), .FWD_EN(0), .ZERO_REG(1), .LINK_REG(15), .FW(3)) u7 (
    .clk(clk), .rst_n(rst7_n), .id_valid(v7), .id_instr(i7), .flush(f7),
    .stall(st7), .hz_a(ha7), .hz_b(hb7), .fwd_a(fa7), .fwd_b(fb7), .stall_cnt(c7));

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  typedef struct {
    int          dut;
    bit          rst;
    bit          valid;
    logic [15:0] instr;
    bit          flush;
    logic [8:0]  exp;
    int          cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input int dut, input bit rst, input bit valid, input logic [15:0] instr,
                     input bit flush, input logic st, input logic ha, input logic hb,
                     input logic [2:0] fa, input logic [2:0] fb, input int cnt);
    vec_t v;
    v.dut = dut; v.rst = rst; v.valid = valid; v.instr = instr; v.flush = flush;
    v.exp = {st, ha, hb, fa, fb};
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0; f0 = 1'b0; i0 = '0;
    v1 = 1'b0; f1 = 1'b0; i1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [8:0] got, e;
    if (v.rst) do_reset();
    v0 = (v.dut == 0) ? v.valid : 1'b0;
    i0 = v.instr;
    f0 = (v.dut == 0) ? v.flush : 1'b0;
    v1 = (v.dut == 1) ? v.valid : 1'b0;
    i1 = v.instr;
    f1 = (v.dut == 1) ? v.flush : 1'b0;
    exp_q.push_back(v.exp);
    @(negedge clk);
    got = (v.dut == 0) ? {st0, ha0, hb0, fa0, fb0} : {st1, ha1, hb1, fa1, fb1};
    e = exp_q.pop_front();
    check($sformatf("vec%0d outs{stall,hz_a,hz_b,fwd_a,fwd_b}", idx), 32'(got), 32'(e));
    if (v.cnt >= 0)
      check($sformatf("vec%0d stall_cnt", idx), (v.dut == 0) ? 32'(c0) : 32'(c1), 32'(v.cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic saturation_run();
    rst7_n = 1'b0; v7 = 1'b0; f7 = 1'b0; i7 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst7_n = 1'b1;
    @(posedge clk);
    #1;
    // ADD R1,R1,R1 held forever: issues once, then stalls DEPTH cycles, repeat.
    v7 = 1'b1; i7 = 16'h0111;
    @(negedge clk);
    check("sat first issue stall", 32'(st7), 32'd0);
    repeat (7) @(negedge clk);
    check("sat 7th stall", 32'(st7), 32'd1);
    @(negedge clk);
    check("sat drained stall", 32'(st7), 32'd0);
    check("sat cnt after drain", 32'(c7), 32'd7);
    repeat (76000) @(posedge clk);
    #1;
    check("sat stall_cnt saturated", 32'(c7), 32'hFFFF);
    v7 = 1'b0;
  endtask

  task automatic reset_mid_stall();
    do_reset();
    v0 = 1'b1; f0 = 1'b0; i0 = 16'h0123;
    @(posedge clk); #1;
    i0 = 16'h1415;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid stall before reset", 32'(st0), 32'd1);
    check("mid cnt before reset", 32'(c0), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid stall during reset", 32'(st0), 32'd0);
    check("mid hz_a during reset", 32'(ha0), 32'd0);
    check("mid cnt during reset", 32'(c0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("post reset stall", 32'(st0), 32'd0);
    check("post reset cnt", 32'(c0), 32'd0);
    @(posedge clk); #1;
    v0 = 1'b0;
  endtask

  task automatic table_run();
    // dut rst valid instr flush | stall hz_a hz_b fwd_a fwd_b | cnt (-1 = skip)
    add(0, 1, 1, 16'h0123, 0, 0, 0, 0, 0, 0, 0);   // ADD R1,R2,R3
    add(0, 0, 1, 16'h1415, 0, 1, 1, 0, 0, 0, 0);   // SUB R4,R1,R5 stalls 3 cycles
    add(0, 0, 1, 16'h1415, 0, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 16'h1415, 0, 1, 1, 0, 0, 0, 2);
    add(0, 0, 1, 16'h1415, 0, 0, 0, 0, 0, 0, 3);
    add(1, 1, 1, 16'h8120, 0, 0, 0, 0, 0, 0, 0);   // LW R1
    add(1, 0, 1, 16'h0211, 0, 1, 1, 1, 1, 1, 0);   // load-use on both operands
    add(1, 0, 1, 16'h0211, 0, 0, 0, 0, 2, 2, 1);
    add(1, 1, 1, 16'h0123, 0, 0, 0, 0, 0, 0, 0);   // ADD R1
    add(1, 0, 1, 16'hB100, 0, 0, 0, 0, 1, 0, -1);  // LLB R1 forwards from ADD
    add(1, 0, 1, 16'h9130, 0, 0, 0, 0, 1, 0, 0);   // SW rd=R1: youngest wins
    add(0, 1, 1, 16'h0023, 0, 0, 0, 0, 0, 0, 0);   // ADD R0 never tracked
    add(0, 0, 1, 16'h3500, 0, 0, 0, 0, 0, 0, -1);  // OR R5,R0,R0
    add(0, 0, 1, 16'hD000, 0, 0, 0, 0, 0, 0, -1);  // JAL writes R15
    add(0, 0, 1, 16'hEF00, 0, 1, 1, 0, 0, 0, 0);   // JR R15
    add(0, 0, 1, 16'hEF00, 0, 1, 1, 0, 0, 0, -1);
    add(0, 0, 1, 16'hEF00, 0, 1, 1, 0, 0, 0, -1);
    add(0, 0, 1, 16'hEF00, 0, 0, 0, 0, 0, 0, 3);
    add(0, 1, 1, 16'h0123, 0, 0, 0, 0, 0, 0, 0);   // ADD R1
    add(0, 0, 1, 16'h0615, 1, 0, 0, 0, 0, 0, 0);   // flushed hazard; R6 not recorded
    add(0, 0, 1, 16'h1765, 0, 0, 0, 0, 0, 0, 0);   // reads R6: clear
    add(0, 0, 1, 16'h1415, 0, 1, 1, 0, 0, 0, 0);   // R1 now at stage 3
    add(0, 0, 1, 16'h1415, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 16'h0123, 0, 0, 0, 0, 0, 0, 0);   // ADD R1
    add(0, 0, 0, 16'h0231, 0, 0, 0, 0, 0, 0, 0);   // invalid slot masks hazard
    add(0, 0, 1, 16'h0231, 0, 1, 0, 1, 0, 0, 0);   // hazard on operand B
    add(0, 0, 1, 16'h0231, 0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 16'h0231, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 1, 16'hC000, 0, 0, 0, 0, 0, 0, 0);   // B
    add(0, 0, 1, 16'h9720, 0, 0, 0, 0, 0, 0, -1);  // SW R7 (no write)
    add(0, 0, 1, 16'hE700, 0, 0, 0, 0, 0, 0, 0);   // JR R7: no hazard
    foreach (vecs[n]) apply(vecs[n], n);
  endtask

  initial begin
    rst_n = 1'b0; rst7_n = 1'b0;
    v0 = 1'b0; f0 = 1'b0; i0 = '0;
    v1 = 1'b0; f1 = 1'b0; i1 = '0;
    v7 = 1'b0; f7 = 1'b0; i7 = '0;
    fork
      saturation_run();
      begin
        table_run();
        reset_mid_stall();
      end
    join
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: time limit reached before completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
